// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath widths, opcode encoding and the EX/MEM
// memory-handshake state.
package cpu_types_pkg;

  localparam int unsigned CPU_WORD_W     = 32;
  localparam int unsigned CPU_REG_ADDR_W = 5;
  localparam int unsigned CPU_OP_W       = 6;

  typedef logic [CPU_WORD_W-1:0]     word_t;
  typedef logic [CPU_REG_ADDR_W-1:0] regbits_t;

  // MIPS primary opcode field.
  typedef enum logic [CPU_OP_W-1:0] {
    RTYPE = 6'b000000,
    J     = 6'b000010,
    JAL   = 6'b000011,
    BEQ   = 6'b000100,
    BNE   = 6'b000101,
    ADDIU = 6'b001001,
    SLTI  = 6'b001010,
    SLTIU = 6'b001011,
    ANDI  = 6'b001100,
    ORI   = 6'b001101,
    XORI  = 6'b001110,
    LUI   = 6'b001111,
    LW    = 6'b100011,
    SW    = 6'b101011,
    HALT  = 6'b111111
  } opcode_t;

  // Data-memory request phase of the MEM-stage instruction.
  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/exmem_if.sv
// Bundle of every exmem port except CLK/RST, with views for the stage
// itself, the hazard unit, the dcache and a bench.
// Debug signals exist only when EXMEM_DEBUG_EN is defined.
interface exmem_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W     = CPU_WORD_W,
  parameter int unsigned REG_ADDR_W = CPU_REG_ADDR_W
);
  logic                  enable;
  logic                  flush;
  logic                  valid_in;
  logic [WORD_W-1:0]     alu_out_in;
  logic [WORD_W-1:0]     rdat2_in;
  logic [WORD_W-1:0]     pcplus4_in;
  logic [REG_ADDR_W-1:0] wsel_in;
  logic                  regWEN_in;
  logic                  MemToReg_in;
  logic                  dMemREN_in;
  logic                  dMemWEN_in;
  logic                  Halt_in;
  logic                  JType_in;
  logic                  dhit;
  logic [WORD_W-1:0]     dmemload;
  logic                  dmemREN;
  logic                  dmemWEN;
  logic [WORD_W-1:0]     dmemaddr;
  logic [WORD_W-1:0]     dmemstore;
  logic                  mem_busy;
  logic                  valid_out;
  logic [WORD_W-1:0]     alu_out_out;
  logic [WORD_W-1:0]     pcplus4_out;
  logic [REG_ADDR_W-1:0] wsel_out;
  logic                  regWEN_out;
  logic                  MemToReg_out;
  logic                  JType_out;
  logic [WORD_W-1:0]     load_data_out;
  logic                  halt_out;
`ifdef EXMEM_DEBUG_EN
  logic [WORD_W-1:0]     instr_in;
  logic [WORD_W-1:0]     instr_out;
  logic [WORD_W-1:0]     next_pc_in;
  logic [WORD_W-1:0]     next_pc_out;
  logic [REG_ADDR_W-1:0] rs_in;
  logic [REG_ADDR_W-1:0] rs_out;
  opcode_t               InstrOp_in;
  opcode_t               InstrOp_out;
`endif

  modport exmem (
    input  enable, flush, valid_in, alu_out_in, rdat2_in, pcplus4_in, wsel_in,
           regWEN_in, MemToReg_in, dMemREN_in, dMemWEN_in, Halt_in, JType_in,
           dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy, valid_out,
           alu_out_out, pcplus4_out, wsel_out, regWEN_out, MemToReg_out,
           JType_out, load_data_out, halt_out
`ifdef EXMEM_DEBUG_EN
    ,
    input  instr_in, next_pc_in, rs_in, InstrOp_in,
    output instr_out, next_pc_out, rs_out, InstrOp_out
`endif
  );

  modport hazard (
    output enable, flush,
    input  mem_busy, halt_out
  );

  modport dcache (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );

  modport tb (
    output enable, flush, valid_in, alu_out_in, rdat2_in, pcplus4_in, wsel_in,
           regWEN_in, MemToReg_in, dMemREN_in, dMemWEN_in, Halt_in, JType_in,
           dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy, valid_out,
           alu_out_out, pcplus4_out, wsel_out, regWEN_out, MemToReg_out,
           JType_out, load_data_out, halt_out
`ifdef EXMEM_DEBUG_EN
    ,
    output instr_in, next_pc_in, rs_in, InstrOp_in,
    input  instr_out, next_pc_out, rs_out, InstrOp_out
`endif
  );

endinterface

// File: rtl/exmem_memfsm.sv
// Data-memory handshake for the MEM-stage instruction: issues the dcache
// request, stalls the pipe until dhit, captures read data.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   advance             stage register is loading this cycle
//   load_mem            the loaded contents are a valid, unflushed memory op
//   ren, wen            latched memory controls of the MEM-stage instruction
//   addr, store         latched address / store data
//   dhit, dmemload      dcache completion and read data
//   dmemREN, dmemWEN, dmemaddr, dmemstore   cache request (decoded from state)
//   mem_busy            stall request (decoded from state)
//   load_data_out       captured read data (registered)
module exmem_memfsm
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W = CPU_WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              advance,
  input  logic              load_mem,
  input  logic              ren,
  input  logic              wen,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] store,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_busy,
  output logic [WORD_W-1:0] load_data_out
);

  mem_state_t        state_q, state_d;
  logic [WORD_W-1:0] load_data_q, load_data_d;

  // State and load-data registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= M_IDLE;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
    end
  end

  // Next state, request decode and read-data capture.
  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    dmemaddr    = '0;
    dmemstore   = '0;
    mem_busy    = 1'b0;
    unique case (state_q)
      // DONE keeps requests low so a hazard stall never re-issues the access.
      M_IDLE, M_DONE: begin
        if (advance) state_d = load_mem ? M_WAIT : M_IDLE;
      end
      M_WAIT: begin
        mem_busy  = 1'b1;
        // REN together with WEN is treated as a write.
        dmemREN   = ren & ~wen;
        dmemWEN   = wen;
        dmemaddr  = addr;
        dmemstore = store;
        if (dhit) begin
          if (ren & ~wen) load_data_d = dmemload;
          state_d = M_DONE;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  assign load_data_out = load_data_q;

endmodule

// File: rtl/exmem.sv
// EX/MEM pipeline register: latches EX results and surviving control,
// owns the dcache handshake via exmem_memfsm, and holds a sticky halt.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   enable, flush             hazard-unit advance permit / bubble select
//   *_in                      EX-stage fields
//   dhit, dmemload            dcache completion and read data
//   dmemREN/WEN/addr/store    dcache request (decoded from FSM state)
//   mem_busy                  stall request (decoded from FSM state)
//   *_out, load_data_out      registered stage contents
//   halt_out                  sticky halt
// Optional: `define EXMEM_DEBUG_EN adds instr/next_pc/rs/InstrOp pass-through.
module exmem
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W     = CPU_WORD_W,
  parameter int unsigned REG_ADDR_W = CPU_REG_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [WORD_W-1:0]     alu_out_in,
  input  logic [WORD_W-1:0]     rdat2_in,
  input  logic [WORD_W-1:0]     pcplus4_in,
  input  logic [REG_ADDR_W-1:0] wsel_in,
  input  logic                  regWEN_in,
  input  logic                  MemToReg_in,
  input  logic                  dMemREN_in,
  input  logic                  dMemWEN_in,
  input  logic                  Halt_in,
  input  logic                  JType_in,
  input  logic                  dhit,
  input  logic [WORD_W-1:0]     dmemload,
  output logic                  dmemREN,
  output logic                  dmemWEN,
  output logic [WORD_W-1:0]     dmemaddr,
  output logic [WORD_W-1:0]     dmemstore,
  output logic                  mem_busy,
  output logic                  valid_out,
  output logic [WORD_W-1:0]     alu_out_out,
  output logic [WORD_W-1:0]     pcplus4_out,
  output logic [REG_ADDR_W-1:0] wsel_out,
  output logic                  regWEN_out,
  output logic                  MemToReg_out,
  output logic                  JType_out,
  output logic [WORD_W-1:0]     load_data_out,
  output logic                  halt_out
`ifdef EXMEM_DEBUG_EN
  ,
  input  logic [WORD_W-1:0]     instr_in,
  output logic [WORD_W-1:0]     instr_out,
  input  logic [WORD_W-1:0]     next_pc_in,
  output logic [WORD_W-1:0]     next_pc_out,
  input  logic [REG_ADDR_W-1:0] rs_in,
  output logic [REG_ADDR_W-1:0] rs_out,
  input  opcode_t               InstrOp_in,
  output opcode_t               InstrOp_out
`endif
);

  logic                  advance_c;
  logic                  load_mem_c;
  logic                  valid_q, valid_d;
  logic [WORD_W-1:0]     alu_q, alu_d;
  logic [WORD_W-1:0]     rdat2_q, rdat2_d;
  logic [WORD_W-1:0]     pc4_q, pc4_d;
  logic [REG_ADDR_W-1:0] wsel_q, wsel_d;
  logic                  regwen_q, regwen_d;
  logic                  memtoreg_q, memtoreg_d;
  logic                  ren_q, ren_d;
  logic                  wen_q, wen_d;
  logic                  jtype_q, jtype_d;
  logic                  halt_q, halt_d;

  // Stage field registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      rdat2_q    <= '0;
      pc4_q      <= '0;
      wsel_q     <= '0;
      regwen_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      jtype_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      alu_q      <= alu_d;
      rdat2_q    <= rdat2_d;
      pc4_q      <= pc4_d;
      wsel_q     <= wsel_d;
      regwen_q   <= regwen_d;
      memtoreg_q <= memtoreg_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      jtype_q    <= jtype_d;
      halt_q     <= halt_d;
    end
  end

  // Advance/flush/hold selection; a flushed advance loads an all-zero bubble.
  always_comb begin
    advance_c  = enable & ~mem_busy & ~halt_q;
    load_mem_c = advance_c & ~flush & valid_in & (dMemREN_in | dMemWEN_in);
    valid_d    = valid_q;
    alu_d      = alu_q;
    rdat2_d    = rdat2_q;
    pc4_d      = pc4_q;
    wsel_d     = wsel_q;
    regwen_d   = regwen_q;
    memtoreg_d = memtoreg_q;
    ren_d      = ren_q;
    wen_d      = wen_q;
    jtype_d    = jtype_q;
    halt_d     = halt_q | (advance_c & ~flush & valid_in & Halt_in);
    if (advance_c) begin
      if (flush) begin
        valid_d    = 1'b0;
        alu_d      = '0;
        rdat2_d    = '0;
        pc4_d      = '0;
        wsel_d     = '0;
        regwen_d   = 1'b0;
        memtoreg_d = 1'b0;
        ren_d      = 1'b0;
        wen_d      = 1'b0;
        jtype_d    = 1'b0;
      end else begin
        valid_d    = valid_in;
        alu_d      = alu_out_in;
        rdat2_d    = rdat2_in;
        pc4_d      = pcplus4_in;
        wsel_d     = wsel_in;
        regwen_d   = regWEN_in;
        memtoreg_d = MemToReg_in;
        ren_d      = dMemREN_in;
        wen_d      = dMemWEN_in;
        jtype_d    = JType_in;
      end
    end
  end

  assign valid_out    = valid_q;
  assign alu_out_out  = alu_q;
  assign pcplus4_out  = pc4_q;
  assign wsel_out     = wsel_q;
  assign regWEN_out   = regwen_q;
  assign MemToReg_out = memtoreg_q;
  assign JType_out    = jtype_q;
  assign halt_out     = halt_q;

  exmem_memfsm #(
    .WORD_W (WORD_W)
  ) u_memfsm (
    .CLK           (CLK),
    .RST           (RST),
    .advance       (advance_c),
    .load_mem      (load_mem_c),
    .ren           (ren_q),
    .wen           (wen_q),
    .addr          (alu_q),
    .store         (rdat2_q),
    .dhit          (dhit),
    .dmemload      (dmemload),
    .dmemREN       (dmemREN),
    .dmemWEN       (dmemWEN),
    .dmemaddr      (dmemaddr),
    .dmemstore     (dmemstore),
    .mem_busy      (mem_busy),
    .load_data_out (load_data_out)
  );

`ifdef EXMEM_DEBUG_EN
  logic [WORD_W-1:0]     instr_q, instr_d;
  logic [WORD_W-1:0]     npc_q, npc_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d;
  opcode_t               op_q, op_d;

  // Debug pass-through registers; opcode resets to BEQ.
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_q <= '0;
      npc_q   <= '0;
      rs_q    <= '0;
      op_q    <= BEQ;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      rs_q    <= rs_d;
      op_q    <= op_d;
    end
  end

  // Same advance/flush/hold rules as the main fields.
  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    rs_d    = rs_q;
    op_d    = op_q;
    if (advance_c) begin
      if (flush) begin
        instr_d = '0;
        npc_d   = '0;
        rs_d    = '0;
        op_d    = RTYPE;
      end else begin
        instr_d = instr_in;
        npc_d   = next_pc_in;
        rs_d    = rs_in;
        op_d    = InstrOp_in;
      end
    end
  end

  assign instr_out   = instr_q;
  assign next_pc_out = npc_q;
  assign rs_out      = rs_q;
  assign InstrOp_out = op_q;
`endif

endmodule
